// File: rtl/ct_vfalu_wb_buf.sv
// Writeback staging buffer after the vfalu ex3 result mux: in-order FIFO of FP results
// presented to the register-file write port, with sticky fflags and overflow tracking.
module ct_vfalu_wb_buf #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned PREG_W = 7,
    parameter int unsigned IID_W  = 7,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst,
    input  logic              ex3_inst_vld,
    input  logic [PREG_W-1:0] ex3_dst_preg,
    input  logic [IID_W-1:0]  ex3_iid,
    input  logic [DATA_W-1:0] pipex_dp_ex3_vfalu_freg_data,
    input  logic [4:0]        pipex_dp_ex3_vfalu_ereg_data,
    input  logic              rtu_yy_xx_flush,
    input  logic              wb_grant,
    input  logic              fflags_clr,
    output logic              wb_req_vld,
    output logic [PREG_W-1:0] wb_preg,
    output logic [DATA_W-1:0] wb_data,
    output logic [IID_W-1:0]  wb_iid,
    output logic [4:0]        wb_fflags,
    output logic              buf_full,
    output logic              buf_empty,
    output logic [4:0]        fflags_acc,
    output logic              ovfl_err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [4:0]        fflags_acc_q, fflags_acc_d;
    logic              ovfl_err_q, ovfl_err_d;

    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [PREG_W-1:0] preg_q  [DEPTH];
    logic [IID_W-1:0]  iid_q   [DEPTH];
    logic [4:0]        flags_q [DEPTH];

    logic push;
    logic pop;
    logic overflow;

    assign buf_full   = (count_q == CNT_W'(DEPTH));
    assign buf_empty  = (count_q == '0);
    assign wb_req_vld = ~buf_empty;

    assign pop      = wb_req_vld & wb_grant;
    // A pop in the same cycle frees the slot, so a full buffer can still accept.
    assign push     = ex3_inst_vld & ~rtu_yy_xx_flush & (~buf_full | pop);
    assign overflow = ex3_inst_vld & ~rtu_yy_xx_flush & buf_full & ~pop;

    assign wb_preg   = preg_q[rd_ptr_q];
    assign wb_data   = data_q[rd_ptr_q];
    assign wb_iid    = iid_q[rd_ptr_q];
    assign wb_fflags = flags_q[rd_ptr_q];

    assign fflags_acc = fflags_acc_q;
    assign ovfl_err   = ovfl_err_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (rtu_yy_xx_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Clear takes effect before the retiring entry's flags are merged in.
    always_comb begin
        fflags_acc_d = fflags_clr ? 5'b0 : fflags_acc_q;
        if (pop) begin
            fflags_acc_d = fflags_acc_d | wb_fflags;
        end
        ovfl_err_d = ovfl_err_q | overflow;
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            fflags_acc_q <= '0;
            ovfl_err_q   <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            fflags_acc_q <= fflags_acc_d;
            ovfl_err_q   <= ovfl_err_d;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i]  <= '0;
                preg_q[i]  <= '0;
                iid_q[i]   <= '0;
                flags_q[i] <= '0;
            end
        end else if (push) begin
            data_q[wr_ptr_q]  <= pipex_dp_ex3_vfalu_freg_data;
            preg_q[wr_ptr_q]  <= ex3_dst_preg;
            iid_q[wr_ptr_q]   <= ex3_iid;
            flags_q[wr_ptr_q] <= pipex_dp_ex3_vfalu_ereg_data;
        end
    end

endmodule

// File: doc/ct_vfalu_wb_buf.md
Name: ct_vfalu_wb_buf

Overview:
- Writeback staging buffer directly downstream of the vfalu pipe6 ex3 result mux.
- Captures the ex3 FP result (64-bit freg data plus 5-bit exception flags) with its destination preg and iid into a small in-order FIFO.
- Presents the FIFO head to the FP register-file write port under a req/grant handshake.
- Accumulates sticky fflags for retired entries and handles pipeline flush.

Parameters:
- DATA_W, 64, width of freg result data.
- PREG_W, 7, width of destination physical register index.
- IID_W, 7, width of instruction id.
- DEPTH, 2, FIFO entries (power of two, >=2).

Ports:
- forever_cpuclk  in  1  clock; all state updates on rising edge.
- cpurst  in  1  reset, synchronous, active-high.
- ex3_inst_vld  in  1  ex3 result valid this cycle (push request).
- ex3_dst_preg  in  PREG_W  destination preg of ex3 result.
- ex3_iid  in  IID_W  iid of ex3 result.
- pipex_dp_ex3_vfalu_freg_data  in  DATA_W  ex3 result data.
- pipex_dp_ex3_vfalu_ereg_data  in  5  ex3 exception flags {NV,DZ,OF,UF,NX}.
- rtu_yy_xx_flush  in  1  pipeline flush.
- wb_grant  in  1  register-file write port grant.
- fflags_clr  in  1  clear sticky accumulator.
- wb_req_vld  out  1  head entry valid / write request.
- wb_preg  out  PREG_W  head destination preg.
- wb_data  out  DATA_W  head result data.
- wb_iid  out  IID_W  head iid.
- wb_fflags  out  5  head exception flags.
- buf_full  out  1  count == DEPTH (upstream issue stall).
- buf_empty  out  1  count == 0.
- fflags_acc  out  5  sticky OR of fflags of retired entries.
- ovfl_err  out  1  sticky overflow error.

Behaviour:
- Reset (cpurst=1 at a clock edge):
  - rd_ptr, wr_ptr and count become 0.
  - All entry payloads become 0.
  - fflags_acc=0, ovfl_err=0.
  - Therefore wb_req_vld=0, buf_empty=1, buf_full=0, and wb_* = 0.
  - Reset overrides every other input in the same cycle.
- Handshakes:
  - push = ex3_inst_vld & ~rtu_yy_xx_flush & (~buf_full | pop).
  - pop = wb_req_vld & wb_grant.
- Outputs:
  - wb_req_vld = ~buf_empty.
  - wb_* are driven combinationally from the entry at rd_ptr; no added latency beyond the register.
- Latency: a push at cycle N makes its entry visible as the head at N+1 at the earliest (when the buffer was empty). No same-cycle bypass.
- Ordering: strictly in order; pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Count update: push only → +1; pop only → -1; push and pop together → unchanged, valid also when full (the slot is freed in the same cycle).
- Overflow: ex3_inst_vld & ~flush & buf_full & ~pop:
  - The result is dropped and ovfl_err is set sticky.
  - ovfl_err is cleared only by reset.
  - FIFO contents are unchanged.
- Accumulator: on pop, fflags_acc |= head fflags.
  - fflags_clr with no pop → fflags_acc = 0.
  - fflags_clr together with pop → fflags_acc = head fflags (the clear applies first, then the OR).
- Flush (rtu_yy_xx_flush=1):
  - Next cycle: pointers and count are 0, so wb_req_vld=0.
  - The ex3 push in the flush cycle is discarded.
  - A grant in the flush cycle still counts as a pop for fflags_acc; the register-file write is accepted by the consumer.
  - Flush has priority over push; it has no effect on ovfl_err.
- Underflow is impossible by construction: pop requires wb_req_vld.
- Payload writes occur only on push. Stale payload of freed entries is don't-care internally, but wb_* must reflect the rd_ptr entry at all times.

Test Plan:
- Reset, then single push: preg=7'h05, data=64'h3FF0_0000_0000_0000, ereg=5'b00001, grant held at 1 → wb_req_vld=1 exactly one cycle later with matching fields; next cycle buf_empty=1 and fflags_acc=5'b00001.
- Grant held 0, push A then B → buf_full=1 after B. Push C while full → ovfl_err=1 and head remains A. Then grant for two cycles → A then B in order, and buf_empty=1.
- Full buffer, simultaneous push C and grant → A retires, count stays 2, and the head sequence is B then C (pointer wrap checked).
- Two entries pending, flush asserted together with ex3_inst_vld and wb_grant → next cycle wb_req_vld=0 and count=0; fflags_acc includes only the granted head's flags; the flush-cycle push is absent.
- Accumulator: retire ereg=5'b10000 then 5'b00100 → fflags_acc=5'b10100. Then fflags_clr together with a pop of ereg 5'b00010 → fflags_acc=5'b00010.
- Assert cpurst mid-operation with 2 entries and ovfl_err=1 → next cycle all outputs are 0 and buf_empty=1.
